// File: rtl/word_uart_tx.sv
// Word-to-UART serializer: pops one 32-bit word from an upstream FIFO and sends it
// as four back-to-back 8N1 frames. Only one word is in flight at a time.
module word_uart_tx #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_read,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;

  logic [1:0]  byte_sel;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_nxt;
  logic        baud_end;

  // Byte currently on the line, chosen from the latched word by byte index and order.
  always_comb begin
    byte_sel = (MSB_FIRST != 0) ? (2'd3 - byte_q) : byte_q;
    cur_byte = word_q[{byte_sel, 3'b000} +: 8];
    bit_nxt  = bit_q + 3'd1;
    baud_end = (baud_q == BaudLast);
  end

  // Next-state logic; tx is computed one cycle ahead so the line is driven from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    tx_d    = tx_q;
    read_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_in_valid) begin
          word_d  = data_in;
          state_d = StStart;
          tx_d    = 1'b0;
          read_d  = 1'b1;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            // Last stop bit done: word complete, free for the next capture.
            state_d = StIdle;
            byte_d  = '0;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
    end
  end

  assign tx           = tx_q;
  assign data_in_read = read_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: two instances (MSB-first and LSB-first, CLK_DIV=4), each
// watched by a UART frame decoder feeding a byte scoreboard.
module tb_word_uart_tx;

  localparam int unsigned Div = 4;

  logic        clk;
  logic        rst_a, rst_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        read_a, read_b;
  logic        tx_a, tx_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Expected and decoded bytes as {stop_bit, data}.
  logic [8:0] a_exp[$];
  logic [8:0] a_got[$];
  logic [8:0] b_exp[$];
  logic [8:0] b_got[$];

  int         a_reads = 0;
  bit         a_act = 0;
  int         a_cnt = 0;
  logic [7:0] a_sh;
  bit         b_act = 0;
  int         b_cnt = 0;
  logic [7:0] b_sh;

  word_uart_tx #(.CLK_DIV(Div), .MSB_FIRST(1)) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .data_in      (data_a),
    .data_in_valid(valid_a),
    .data_in_read (read_a),
    .tx           (tx_a),
    .busy         (busy_a)
  );

  word_uart_tx #(.CLK_DIV(Div), .MSB_FIRST(0)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .data_in      (data_b),
    .data_in_valid(valid_b),
    .data_in_read (read_b),
    .tx           (tx_b),
    .busy         (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame decoders: sample mid-bit on falling edges, push {stop, byte} when a frame ends.
  always @(negedge clk) begin
    if (read_a === 1'b1) a_reads <= a_reads + 1;
    if (rst_a) begin
      a_act <= 1'b0;
    end else if (!a_act) begin
      if (tx_a === 1'b0) begin
        a_act <= 1'b1;
        a_cnt <= 1;
      end
    end else begin
      if (a_cnt >= 6 && a_cnt <= 34 && (a_cnt % 4) == 2) a_sh <= {tx_a, a_sh[7:1]};
      if (a_cnt == 38) begin
        a_act <= 1'b0;
        a_got.push_back({tx_a, a_sh});
      end
      a_cnt <= a_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      b_act <= 1'b0;
    end else if (!b_act) begin
      if (tx_b === 1'b0) begin
        b_act <= 1'b1;
        b_cnt <= 1;
      end
    end else begin
      if (b_cnt >= 6 && b_cnt <= 34 && (b_cnt % 4) == 2) b_sh <= {tx_b, b_sh[7:1]};
      if (b_cnt == 38) begin
        b_act <= 1'b0;
        b_got.push_back({tx_b, b_sh});
      end
      b_cnt <= b_cnt + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tx level for frame bit b (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] v, input int b);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return v[b-1];
  endfunction

  task automatic push_a(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) a_exp.push_back({1'b1, w[8*i +: 8]});
  endtask

  task automatic drain_a(input string tag);
    logic [8:0] e;
    while (a_exp.size() > 0) begin
      e = a_exp.pop_front();
      if (a_got.size() == 0) check({tag, " missing"}, 32'hFFFF_FFFF, {23'd0, e});
      else check(tag, {23'd0, a_got.pop_front()}, {23'd0, e});
    end
    check({tag, " extra"}, a_got.size(), 0);
  endtask

  task automatic wait_read_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_a === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int mism, read_n, busy_n, gap, extra, base, tx_bad, busy_bad;
    logic [8:0] e;

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("reset tx", {31'd0, tx_a}, 1);
    check("reset busy", {31'd0, busy_a}, 0);
    check("reset read", {31'd0, read_a}, 0);
    check("reset tx b", {31'd0, tx_b}, 1);

    // Single word, MSB first: exact bit timing of the first frame and busy length.
    push_a(32'h1234_5678);
    @(posedge clk); #1 data_a = 32'h1234_5678; valid_a = 1'b1;
    wait_read_a(ok);
    check("first read", {31'd0, ok}, 1);
    mism = 0; read_n = 0; busy_n = 0;
    for (int k = 0; k < 170; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) valid_a = 1'b0;
      if (k < 40 && tx_a !== frame_bit(8'h12, k / 4)) mism++;
      if (read_a === 1'b1) read_n++;
      if (busy_a === 1'b1) busy_n++;
    end
    check("frame0 bits", mism, 0);
    check("read pulse width", read_n, 1);
    check("busy cycles", busy_n, 160);
    drain_a("word 12345678");

    // Two queued words with valid held high: pops are one minimum word period apart.
    push_a(32'hDEAD_BEEF);
    push_a(32'h0000_0001);
    base = a_reads;
    @(posedge clk); #1 data_a = 32'hDEAD_BEEF; valid_a = 1'b1;
    wait_read_a(ok);
    check("b2b first read", {31'd0, ok}, 1);
    gap = -1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (k == 1) data_a = 32'h0000_0001;
      if (read_a === 1'b1) begin
        gap = k;
        break;
      end
    end
    valid_a = 1'b0;
    check("read gap", gap, 161);
    repeat (170) @(negedge clk);
    check("b2b read count", a_reads - base, 2);
    drain_a("b2b words");

    // Valid toggling every cycle while busy must not cause another pop.
    push_a(32'hCAFE_F00D);
    base = a_reads;
    @(posedge clk); #1 data_a = 32'hCAFE_F00D; valid_a = 1'b1;
    wait_read_a(ok);
    check("toggle read", {31'd0, ok}, 1);
    extra = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      valid_a = ~valid_a;
      if (read_a === 1'b1) extra++;
    end
    valid_a = 1'b0;
    repeat (20) @(negedge clk);
    check("toggle extra pops", extra, 0);
    check("toggle read count", a_reads - base, 1);
    drain_a("toggle word");

    // Reset in the middle of the second byte's data bits.
    a_exp.push_back({1'b1, 8'h55});
    @(posedge clk); #1 data_a = 32'h55AA_33CC; valid_a = 1'b1;
    wait_read_a(ok);
    check("pre-reset read", {31'd0, ok}, 1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) valid_a = 1'b0;
    end
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    check("midreset tx", {31'd0, tx_a}, 1);
    check("midreset busy", {31'd0, busy_a}, 0);
    check("midreset read", {31'd0, read_a}, 0);
    drain_a("pre-reset byte");
    push_a(32'h0F1E_2D3C);
    @(posedge clk); #1 data_a = 32'h0F1E_2D3C; valid_a = 1'b1;
    wait_read_a(ok);
    check("post-reset read", {31'd0, ok}, 1);
    check("post-reset start", {31'd0, tx_a}, 0);
    check("post-reset busy", {31'd0, busy_a}, 1);
    @(negedge clk); valid_a = 1'b0;
    repeat (170) @(negedge clk);
    drain_a("post-reset word");

    // Idle with valid low: line stays high, nothing popped.
    base = a_reads; tx_bad = 0; busy_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_bad++;
      if (busy_a !== 1'b0) busy_bad++;
    end
    check("idle tx high", tx_bad, 0);
    check("idle busy low", busy_bad, 0);
    check("idle no pops", a_reads - base, 0);

    // LSB-first instance.
    b_exp.push_back({1'b1, 8'hD4});
    b_exp.push_back({1'b1, 8'hC3});
    b_exp.push_back({1'b1, 8'hB2});
    b_exp.push_back({1'b1, 8'hA1});
    @(posedge clk); #1 data_b = 32'hA1B2_C3D4; valid_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_b === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("lsb read", {31'd0, ok}, 1);
    @(negedge clk); valid_b = 1'b0;
    repeat (170) @(negedge clk);
    while (b_exp.size() > 0) begin
      e = b_exp.pop_front();
      if (b_got.size() == 0) check("lsb byte missing", 32'hFFFF_FFFF, {23'd0, e});
      else check("lsb byte", {23'd0, b_got.pop_front()}, {23'd0, e});
    end
    check("lsb extra", b_got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
Downstream consumer of Top's 32-bit result stream. Pops one word with a one-cycle read strobe and serializes it as four 8N1 UART bytes on a single tx line toward the host PC. Connects directly to Top's data_out, data_out_valid and data_out_read. Only one word is in flight at a time, so the upstream FIFO in Top provides all buffering.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
MSB_FIRST, 1, 1: send byte [31:24] first; 0: send byte [7:0] first

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  32  word from Top.data_out
data_in_valid  input  1  Top.data_out_valid; high while a word is available
data_in_read  output  1  to Top.data_out_read; one-cycle pop strobe
tx  output  1  UART serial output, idle high
busy  output  1  high from word capture until the last stop bit ends

Behaviour:
- Reset (rst=1 at any edge, including mid-frame): tx=1, data_in_read=0, busy=0, state IDLE, counters cleared. A partially sent word is discarded and not re-popped.
- Rst has priority over all other events.
- All outputs are registered.
- States:
  - IDLE: waits for data_in_valid.
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx=1.
- Capture (edge E0, state IDLE, data_in_valid=1):
  - Latch data_in into word_reg and select byte 0 per MSB_FIRST.
  - After E0: data_in_read=1 for exactly one cycle, tx=0, busy=1, state START.
  - Producer holds data_in until it sees data_in_read. data_in_valid is ignored outside IDLE.
- Bit timing: baud counter counts 0..CLK_DIV-1. Each bit holds tx for exactly CLK_DIV cycles, then advances:
  - START -> DATA bit0 -> ... -> DATA bit7 -> STOP.
- End of STOP:
  - Byte index < 3: increment index, go to START. Back-to-back bytes, no extra gap.
  - Byte index = 3: go to IDLE, busy=0, at edge E0+40*CLK_DIV.
- Earliest next capture is edge E0+40*CLK_DIV+1, so the minimum word period is 40*CLK_DIV+1 cycles.
- Byte order:
  - MSB_FIRST=1: [31:24], [23:16], [15:8], [7:0].
  - MSB_FIRST=0: reverse order.
- Word bookkeeping: exactly one data_in_read pulse per transmitted word. No pop occurs when data_in_valid=0.
- Widths:
  - Baud counter is 16 bits.
  - Bit counter is 3 bits, no wrap beyond 7.
  - Byte counter is 2 bits; the 3->0 transition coincides with the return to IDLE.
- data_in_valid toggling while busy: no effect, no extra pop.

Test Plan:
- CLK_DIV=4, MSB_FIRST=1; rst pulse, then data_in=32'h12345678 with valid=1:
  - data_in_read high for exactly 1 cycle.
  - First frame on tx, 4 cycles per bit: 0,0,1,0,0,1,0,0,0,1 (byte 0x12).
  - Then 0x34, 0x56, 0x78 decode correctly.
  - busy falls 160 cycles after capture.
- Valid held high with two queued words 32'hDEADBEEF and 32'h00000001:
  - Two read pulses, 161 cycles apart.
  - Decoded bytes: DE AD BE EF 00 00 00 01.
- MSB_FIRST=0, word 32'hA1B2C3D4 -> decoded bytes D4 C3 B2 A1.
- rst asserted during the 2nd byte's DATA state:
  - Next cycle: tx=1, busy=0, data_in_read=0.
  - After rst release with valid=1: new capture and a clean START bit. No partial byte resumes.
- Valid low throughout 1000 cycles -> tx constantly 1, no data_in_read pulse, busy=0.
- Valid pulsed 0/1 every cycle during a transmission -> no additional data_in_read until return to IDLE.
